// File: rtl/adder_pkg.sv
// Shared constants for the serial nibble adder.
// Holds the slice width and the FSM state encodings.
package adder_pkg;

    localparam int SLICE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_nibble_adder_if.sv
// Operand and result handshake bundle for the serial nibble adder.
// The master drives operands and consumes results; the slave is the adder.
interface serial_nibble_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        output cin,
        input  out_valid,
        output out_ready,
        input  sum,
        input  cout
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        input  cin,
        output out_valid,
        input  out_ready,
        output sum,
        output cout
    );

endinterface

// File: rtl/rca4_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// Built from a chain of full adders, LSB first.
module rca4_slice
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               ci_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               co_o
);

    logic [SLICE_W:0] c;

    assign c[0] = ci_i;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]  = (a_i[i] & b_i[i]) |
                         (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign co_o = c[SLICE_W];

endmodule

// File: rtl/serial_nibble_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit ripple slice.
// One slice per cycle, LSBs first, carry held in a register.
module serial_nibble_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_nibble_adder_if.slave  bus
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("serial_nibble_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_co;
    logic [IDX_W+1:0]   sl_base;

    assign sl_base = {idx_q, 2'b00};
    assign sl_a    = a_q[sl_base +: SLICE_W];
    assign sl_b    = b_q[sl_base +: SLICE_W];

    rca4_slice u_slice (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .ci_i (carry_q),
        .s_o  (sl_s),
        .co_o (sl_co)
    );

    // acc_q collects slices so sum stays stable until the full result lands
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d[sl_base +: SLICE_W] = sl_s;
                carry_d = sl_co;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    sum_d   = acc_d;
                    cout_d  = sl_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed bench for serial_nibble_adder at WIDTH=16.
// Vector table plus hand-written backpressure, reset and streaming cases.
module tb_serial_nibble_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_nibble_adder_if #(.WIDTH(W)) bus ();

    serial_nibble_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W:0] act,
                       input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // steps until out_valid; returns number of cycles waited
    task automatic wait_done(input string nm, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!bus.out_valid) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] esum, input logic ecout);
        int lat;
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        chk({nm, "_in_ready"}, {16'h0, bus.in_ready}, 17'h1);
        step();
        bus.in_valid = 1'b0;
        wait_done(nm, lat);
        chk({nm, "_latency"}, 17'(lat), 17'd4);
        chk({nm, "_result"}, {bus.cout, bus.sum}, {ecout, esum});
        step();
        chk({nm, "_handoff"}, {15'h0, bus.in_ready, bus.out_valid}, 17'b10);
    endtask

    vec_t vt[8];

    initial begin
        int lat;
        logic [W-1:0] sa[3];
        logic [W-1:0] sb[3];
        logic         sc[3];
        total = 0;
        bad = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;

        vt[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vt[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[5] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0};
        vt[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
        vt[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

        step();
        step();
        rst = 1'b0;
        chk("reset_state",
            {bus.in_ready, bus.out_valid, bus.cout, 14'h0},
            {1'b1, 1'b0, 1'b0, 14'h0});
        chk("reset_sum", {1'b0, bus.sum}, 17'h0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin,
                   vt[i].esum, vt[i].ecout);
        end

        // backpressure in DONE
        bus.a = 16'h0003;
        bus.b = 16'h0004;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.a = 16'h1111;
        bus.b = 16'h2222;
        wait_done("bp", lat);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i),
                {bus.cout, bus.sum}, {1'b0, 16'h0007});
            chk($sformatf("bp_flags%0d", i),
                {15'h0, bus.in_ready, bus.out_valid}, 17'b01);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        chk("bp_release", {15'h0, bus.in_ready, bus.out_valid}, 17'b10);
        step();
        chk("bp_no_accept", {15'h0, bus.in_ready, bus.out_valid}, 17'b10);

        // operands change right after accept
        bus.a = 16'h0F0F;
        bus.b = 16'h0101;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        bus.cin = 1'b1;
        wait_done("opreg", lat);
        chk("opreg_result", {bus.cout, bus.sum}, {1'b0, 16'h1010});
        step();

        // reset during second ADD cycle
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_flags", {15'h0, bus.in_ready, bus.out_valid}, 17'b10);
        chk("rst_mid_sum", {bus.cout, bus.sum}, 17'h0);
        run_op("post_rst", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0);

        // back-to-back with in_valid held high
        sa = '{16'h1111, 16'hF00F, 16'h9999};
        sb = '{16'h2222, 16'h0FF1, 16'h6667};
        sc = '{1'b1, 1'b0, 1'b0};
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [W:0] exp;
            exp = {1'b0, sa[i]} + {1'b0, sb[i]} + {16'h0, sc[i]};
            bus.a = sa[i];
            bus.b = sb[i];
            bus.cin = sc[i];
            chk($sformatf("b2b_ready%0d", i), {16'h0, bus.in_ready}, 17'h1);
            step();
            wait_done($sformatf("b2b%0d", i), lat);
            chk($sformatf("b2b_sum%0d", i), {bus.cout, bus.sum}, exp);
            chk($sformatf("b2b_busy%0d", i), {16'h0, bus.in_ready}, 17'h0);
            step();
            chk($sformatf("b2b_idle%0d", i),
                {15'h0, bus.in_ready, bus.out_valid}, 17'b10);
        end
        bus.in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
